// File: rtl/ghash_engine.sv
// GHASH controller for AES-GCM: folds 128-bit blocks into Y = (Y ^ X) * H by
// driving an external GF(2^128) multiplier of unknown latency, one operation at a time.
module ghash_engine #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] h_i,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [127:0] blk_data_i,
  input  logic         blk_last_i,
  output logic         mul_valid_o,
  output logic [127:0] mul_a_o,
  output logic [127:0] mul_b_o,
  input  logic         mul_valid_i,
  input  logic [127:0] mul_result_i,
  output logic         tag_valid_o,
  output logic [127:0] tag_o,
  output logic         busy_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    WAIT_MUL = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e       state_q, state_d;
  logic [127:0] y_q, y_d;
  logic [127:0] h_q, h_d;
  logic [127:0] mul_a_q, mul_a_d;
  logic [127:0] mul_b_q, mul_b_d;
  logic         mul_valid_q, mul_valid_d;
  logic [127:0] tag_q, tag_d;
  logic         tag_valid_q, tag_valid_d;
  logic         err_q, err_d;
  logic         last_q, last_d;
  logic [7:0]   timer_q, timer_d;
  logic         timer_done;

  assign timer_done = (timer_q == TIMER_LAST);

  always_comb begin
    // NOTE: every _d starts from its held value so no path through the case infers a latch.
    state_d     = state_q;
    y_d         = y_q;
    h_d         = h_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_valid_d = 1'b0;
    tag_d       = tag_q;
    tag_valid_d = 1'b0;
    err_d       = err_q;
    last_d      = last_q;
    timer_d     = timer_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          h_d     = h_i;
          y_d     = '0;
          err_d   = 1'b0;
          state_d = WAIT_BLK;
        end
      end

      WAIT_BLK: begin
        if (start_i) begin
          h_d   = h_i;
          y_d   = '0;
          err_d = 1'b0;
        end else if (blk_valid_i) begin
          mul_a_d     = y_q ^ blk_data_i;
          mul_b_d     = h_q;
          mul_valid_d = 1'b1;
          last_d      = blk_last_i;
          timer_d     = '0;
          state_d     = WAIT_MUL;
        end
      end

      WAIT_MUL: begin
        timer_d = timer_q + 8'd1;
        if (start_i) begin
          // A result still owed by the multiplier must be swallowed before new blocks flow.
          h_d     = h_i;
          y_d     = '0;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = mul_valid_i ? WAIT_BLK : FLUSH;
        end else if (mul_valid_i) begin
          y_d = mul_result_i;
          if (last_q) begin
            tag_d       = mul_result_i;
            tag_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_BLK;
          end
        end else if (timer_done) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      FLUSH: begin
        timer_d = timer_q + 8'd1;
        if (start_i) begin
          h_d   = h_i;
          y_d   = '0;
          err_d = 1'b0;
        end
        if (mul_valid_i || (timer_done && !start_i)) begin
          state_d = WAIT_BLK;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      h_q         <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_valid_q <= 1'b0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b0;
      timer_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      y_q         <= y_d;
      h_q         <= h_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_valid_q <= mul_valid_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      err_q       <= err_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
    end
  end

  assign blk_ready_o = (state_q == WAIT_BLK) && !start_i;
  assign busy_o      = (state_q != IDLE);
  assign mul_valid_o = mul_valid_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign tag_valid_o = tag_valid_q;
  assign tag_o       = tag_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ghash_engine.sv
// Bench for ghash_engine: a behavioural GF(2^128) multiplier with selectable
// latency answers the engine, and tags are compared with a GHASH fold model.
module tb_ghash_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] h_i;
  logic         blk_valid_i;
  logic         blk_ready_o;
  logic [127:0] blk_data_i;
  logic         blk_last_i;
  logic         mul_valid_o;
  logic [127:0] mul_a_o;
  logic [127:0] mul_b_o;
  wire          mul_valid_i;
  wire  [127:0] mul_result_i;
  logic         tag_valid_o;
  logic [127:0] tag_o;
  logic         busy_o;
  logic         err_o;

  always #5 clk = ~clk;

  ghash_engine #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .h_i(h_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_data_i(blk_data_i), .blk_last_i(blk_last_i),
    .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
    .tag_valid_o(tag_valid_o), .tag_o(tag_o), .busy_o(busy_o), .err_o(err_o)
  );

  // GCM multiplication, bit 127 of the vector is the first (x^0) coefficient.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z = '0;
    logic [127:0] v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z ^= v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  logic [127:0] blk_mem [4];

  function automatic logic [127:0] ref_ghash(input logic [127:0] h, input int n);
    logic [127:0] y = '0;
    for (int i = 0; i < n; i++) y = gf_mul(y ^ blk_mem[i], h);
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Multiplier: mode 0 combinational, mode 1 fixed latency, mode 2 bench-driven.
  int           mode = 0;
  int           lat  = 1;
  logic         man_v;
  logic [127:0] man_r;
  logic         model_v;
  logic [127:0] model_r;

  assign mul_valid_i  = (mode == 0) ? mul_valid_o : (mode == 1) ? model_v : man_v;
  assign mul_result_i = (mode == 0) ? gf_mul(mul_a_o, mul_b_o) : (mode == 1) ? model_r : man_r;

  initial begin
    int           cnt = 0;
    logic [127:0] pend = '0;
    model_v = 1'b0;
    model_r = '0;
    forever begin
      @(posedge clk); #1;
      model_v = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_v = 1'b1;
          model_r = pend;
        end
      end
      if (mode == 1 && mul_valid_o) begin
        pend = gf_mul(mul_a_o, mul_b_o);
        cnt  = lat;
      end
    end
  end

  // Protocol monitor, sampled mid low phase.
  int cyc = 0, mv_cnt = 0, tag_cnt = 0, issue_viol = 0, ready_viol = 0;
  int mv_cyc = 0, err_cyc = 0;
  bit outstanding = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (outstanding && blk_ready_o) ready_viol++;
    if (outstanding && mul_valid_o) issue_viol++;
    if (mul_valid_o) begin
      mv_cnt++;
      mv_cyc = cyc;
      outstanding = 1'b1;
    end
    if (mul_valid_i) outstanding = 1'b0;
    if (!busy_o) outstanding = 1'b0;
    if (tag_valid_o) tag_cnt++;
    if (err_o && !err_prev) err_cyc = cyc;
    err_prev = err_o;
  end

  int passed = 0;
  int total  = 0;

  task automatic settle();
    @(negedge clk); #3;
  endtask

  task automatic pulse_start(input logic [127:0] h);
    @(negedge clk);
    start_i = 1'b1;
    h_i     = h;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    blk_valid_i = 1'b1;
    blk_data_i  = d;
    blk_last_i  = last;
    #1;
    while (!blk_ready_o && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    total++;
    if (!blk_ready_o) $display("FAIL blk_accept: blk_ready_o=0 after %0d cycles, expected 1", n);
    else passed++;
    @(posedge clk); #1;
    blk_valid_i = 1'b0;
    blk_last_i  = 1'b0;
  endtask

  task automatic wait_mv();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mul_valid_o && n < 50);
    total++;
    if (!mul_valid_o) $display("FAIL mv_wait: mul_valid_o=0 after %0d cycles, expected 1", n);
    else passed++;
  endtask

  task automatic wait_tag(output logic [127:0] tag);
    int n = 0;
    tag = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!tag_valid_o && n < 100);
    total++;
    if (!tag_valid_o) $display("FAIL tag_wait: tag_valid_o=0 after %0d cycles, expected 1", n);
    else begin
      passed++;
      tag = tag_o;
    end
  endtask

  task automatic run_hash(input logic [127:0] h, input int n, input int max_gap,
                          output logic [127:0] tag);
    pulse_start(h);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_block(blk_mem[i], i == n - 1);
    end
    wait_tag(tag);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({busy_o, blk_ready_o, mul_valid_o, tag_valid_o, err_o} !== 5'b0 ||
        mul_a_o !== '0 || mul_b_o !== '0 || tag_o !== '0) begin
      $display("FAIL reset_outputs: busy=%b ready=%b mv=%b tv=%b err=%b a=%h b=%h tag=%h, expected all 0",
               busy_o, blk_ready_o, mul_valid_o, tag_valid_o, err_o, mul_a_o, mul_b_o, tag_o);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    total++;
    if ({busy_o, blk_ready_o} !== 2'b00) $display("FAIL reset_idle: busy=%b ready=%b, expected 0 0", busy_o, blk_ready_o);
    else passed++;
  endtask

  task automatic test_known_vector();
    logic [127:0] tag;
    int           t0;
    settle();
    t0   = tag_cnt;
    mode = 1;
    lat  = 2;
    blk_mem[0] = 128'h0388dace60b6a392f328c2b971b2fe78;
    blk_mem[1] = 128'h00000000000000000000000000000080;
    run_hash(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2, 2, tag);
    repeat (3) settle();
    total++;
    if (tag !== 128'hf38cbb1ad69223dcc3457ae5b6b0f885)
      $display("FAIL kv_tag: got %h, expected f38cbb1ad69223dcc3457ae5b6b0f885", tag);
    else passed++;
    total++;
    if (tag_cnt - t0 != 1) $display("FAIL kv_tag_count: got %0d, expected 1", tag_cnt - t0);
    else passed++;
    total++;
    if (busy_o !== 1'b0) $display("FAIL kv_busy: got %b, expected 0", busy_o);
    else passed++;
  endtask

  task automatic test_zero_h();
    logic [127:0] tag;
    int           m0, r0;
    settle();
    m0   = mv_cnt;
    r0   = ready_viol;
    mode = 1;
    lat  = 3;
    for (int i = 0; i < 3; i++) blk_mem[i] = rand128();
    run_hash('0, 3, 3, tag);
    settle();
    total++;
    if (tag !== '0) $display("FAIL zh_tag: got %h, expected 0", tag);
    else passed++;
    total++;
    if (mv_cnt - m0 != 3) $display("FAIL zh_mul_pulses: got %0d, expected 3", mv_cnt - m0);
    else passed++;
    total++;
    if (ready_viol - r0 != 0) $display("FAIL zh_ready_low: got %0d ready cycles while outstanding, expected 0", ready_viol - r0);
    else passed++;
  endtask

  task automatic test_latency_gaps();
    logic [127:0] h, exp, tag0, tag7;
    int           i0;
    settle();
    i0 = issue_viol;
    h  = rand128();
    for (int i = 0; i < 4; i++) blk_mem[i] = rand128();
    exp  = ref_ghash(h, 4);
    mode = 0;
    run_hash(h, 4, 3, tag0);
    mode = 1;
    lat  = 7;
    run_hash(h, 4, 3, tag7);
    settle();
    total++;
    if (tag0 !== exp) $display("FAIL lat0_tag: got %h, expected %h", tag0, exp);
    else passed++;
    total++;
    if (tag7 !== exp) $display("FAIL lat7_tag: got %h, expected %h", tag7, exp);
    else passed++;
    total++;
    if (issue_viol - i0 != 0) $display("FAIL single_outstanding: got %0d overlapping issues, expected 0", issue_viol - i0);
    else passed++;
  endtask

  task automatic test_timeout();
    int n = 0;
    int t0;
    settle();
    t0    = tag_cnt;
    mode  = 2;
    man_v = 1'b0;
    pulse_start(rand128());
    send_block(rand128(), 1'b1);
    wait_mv();
    while (!err_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    settle();
    total++;
    if (err_cyc - mv_cyc != 16) $display("FAIL to_err_delay: got %0d cycles, expected 16", err_cyc - mv_cyc);
    else passed++;
    total++;
    if (busy_o !== 1'b0) $display("FAIL to_idle: busy=%b, expected 0", busy_o);
    else passed++;
    repeat (5) settle();
    total++;
    if (err_o !== 1'b1) $display("FAIL to_sticky: err=%b, expected 1", err_o);
    else passed++;
    total++;
    if (tag_cnt - t0 != 0) $display("FAIL to_no_tag: got %0d tags, expected 0", tag_cnt - t0);
    else passed++;
    pulse_start(rand128());
    #1;
    total++;
    if ({err_o, busy_o} !== 2'b01) $display("FAIL to_restart: err=%b busy=%b, expected 0 1", err_o, busy_o);
    else passed++;
  endtask

  task automatic test_flush();
    logic [127:0] h2, x2, tag;
    settle();
    mode  = 2;
    man_v = 1'b0;
    h2    = rand128();
    x2    = rand128();
    pulse_start(rand128());
    send_block(rand128(), 1'b0);
    wait_mv();
    @(negedge clk);
    @(negedge clk);
    start_i = 1'b1;
    h_i     = h2;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    total++;
    if ({busy_o, blk_ready_o} !== 2'b10) $display("FAIL fl_hold: busy=%b ready=%b, expected 1 0", busy_o, blk_ready_o);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    man_v = 1'b1;
    man_r = rand128();
    @(negedge clk);
    man_v = 1'b0;
    #1;
    total++;
    if (blk_ready_o !== 1'b1) $display("FAIL fl_release: ready=%b, expected 1", blk_ready_o);
    else passed++;
    mode = 1;
    lat  = 2;
    send_block(x2, 1'b1);
    wait_tag(tag);
    total++;
    if (tag !== gf_mul(x2, h2)) $display("FAIL fl_tag: got %h, expected %h", tag, gf_mul(x2, h2));
    else passed++;
  endtask

  task automatic test_async_reset();
    int t0;
    settle();
    t0    = tag_cnt;
    mode  = 2;
    man_v = 1'b0;
    pulse_start(rand128());
    send_block(rand128() | 128'h1, 1'b0);
    wait_mv();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy_o, blk_ready_o, mul_valid_o, tag_valid_o, err_o} !== 5'b0)
      $display("FAIL ar_ctrl: busy=%b ready=%b mv=%b tv=%b err=%b, expected all 0",
               busy_o, blk_ready_o, mul_valid_o, tag_valid_o, err_o);
    else passed++;
    total++;
    if (mul_a_o !== '0 || mul_b_o !== '0 || tag_o !== '0)
      $display("FAIL ar_data: a=%h b=%h tag=%h, expected 0", mul_a_o, mul_b_o, tag_o);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_v = 1'b1;
    man_r = rand128() | 128'h1;
    @(negedge clk);
    man_v = 1'b0;
    repeat (3) settle();
    total++;
    if ({busy_o, tag_valid_o} !== 2'b00 || tag_cnt - t0 != 0)
      $display("FAIL ar_late_result: busy=%b tags=%0d, expected 0 0", busy_o, tag_cnt - t0);
    else passed++;
    total++;
    if (tag_o !== '0 || mul_a_o !== '0) $display("FAIL ar_state: tag=%h a=%h, expected 0", tag_o, mul_a_o);
    else passed++;
  endtask

  initial begin
    rst_n       = 1'b0;
    start_i     = 1'b0;
    h_i         = '0;
    blk_valid_i = 1'b0;
    blk_data_i  = '0;
    blk_last_i  = 1'b0;
    man_v       = 1'b0;
    man_r       = '0;
    test_reset();
    test_known_vector();
    test_zero_h();
    test_latency_gaps();
    test_timeout();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
